// File: rtl/wr_bus_arbiter_pkg.sv
// Shared types and constants for the register-write bus arbiter.
// Holds the FSM state, the requester/register counts and the register index type.
package wr_bus_arbiter_pkg;
  localparam int NREQ      = 4;
  localparam int NREG_DFLT = 20;
  localparam int IDX_W     = 5;

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/wr_bus_arbiter_rr_pick4.sv
// Round-robin picker: one-hot winner is the first set request at or after ptr, mod 4.
// Purely combinational, zero latency, no backpressure.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);
  logic       found;
  logic [1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wr_bus_arbiter.sv
// 4-way round-robin register-write arbiter with burst lock; outputs registered, 1-cycle latency.
// Requesters hold Req until Grant; others wait while a locked owner bursts.
module wr_bus_arbiter
  import wr_bus_arbiter_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NREG      = NREG_DFLT,
  parameter int MAX_BURST = 8
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ-1:0]        Lock,
  input  logic [NREQ*IDX_W-1:0]  Req_dest,
  input  logic [NREQ*DATA_W-1:0] Req_data,
  output logic [NREQ-1:0]        Grant,
  output logic [NREG-1:0]        WRDec_out,
  output logic [DATA_W-1:0]      Bus_out,
  output logic                   Err
);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          owner_q, owner_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREG-1:0]     wrdec_q, wrdec_d;
  logic [DATA_W-1:0]   bus_q, bus_d;
  logic                err_q, err_d;

  logic [NREQ-1:0]     idle_req;
  logic [NREQ-1:0]     pick;
  logic                srv_vld;
  logic [1:0]          srv_idx;
  reg_idx_t            sel_dest;
  reg_idx_t            dest_a [NREQ];
  logic [DATA_W-1:0]   data_a [NREQ];

  // A requester granted last cycle still shows Req this cycle; mask it so it is not served twice.
  assign idle_req = Req & ~grant_q;

  rr_pick4 u_pick (
    .req (idle_req),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      dest_a[i] = Req_dest[IDX_W*i +: IDX_W];
      data_a[i] = Req_data[DATA_W*i +: DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    bcnt_d   = bcnt_q;
    grant_d  = '0;
    wrdec_d  = '0;
    bus_d    = bus_q;
    err_d    = 1'b0;
    srv_vld  = 1'b0;
    srv_idx  = owner_q;
    sel_dest = '0;

    case (state_q)
      IDLE: begin
        if (|pick) begin
          srv_vld = 1'b1;
          srv_idx = oh2idx(pick);
          ptr_d   = srv_idx + 2'd1;
          if (Lock[srv_idx]) begin
            state_d = LOCKED;
            owner_d = srv_idx;
            bcnt_d  = BCNT_W'(1);
          end
        end
      end
      LOCKED: begin
        // Exit cycle issues no grant; the pointer moves past the owner.
        if (Req[owner_q] && Lock[owner_q] && (bcnt_q < BCNT_W'(MAX_BURST))) begin
          srv_vld = 1'b1;
          bcnt_d  = bcnt_q + BCNT_W'(1);
        end else begin
          state_d = IDLE;
          ptr_d   = owner_q + 2'd1;
          bcnt_d  = '0;
        end
      end
    endcase

    if (srv_vld) begin
      sel_dest         = dest_a[srv_idx];
      grant_d[srv_idx] = 1'b1;
      bus_d            = data_a[srv_idx];
      if (int'(sel_dest) >= NREG) begin
        err_d = 1'b1;
      end else begin
        for (int r = 0; r < NREG; r++) begin
          wrdec_d[r] = (int'(sel_dest) == r);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      bcnt_q  <= '0;
      grant_q <= '0;
      wrdec_q <= '0;
      bus_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
      grant_q <= grant_d;
      wrdec_q <= wrdec_d;
      bus_q   <= bus_d;
      err_q   <= err_d;
    end
  end

  assign Grant     = grant_q;
  assign WRDec_out = wrdec_q;
  assign Bus_out   = bus_q;
  assign Err       = err_q;
endmodule

// File: tb/tb_wr_bus_arbiter.sv
// Directed bench for wr_bus_arbiter: hand-computed vectors plus per-cycle one-hot checks.
module tb_wr_bus_arbiter;
  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic [3:0]  Req = '0;
  logic [3:0]  Lock = '0;
  logic [19:0] Req_dest = '0;
  logic [63:0] Req_data = '0;
  logic [3:0]  Grant;
  logic [19:0] WRDec_out;
  logic [15:0] Bus_out;
  logic        Err;

  int n_chk = 0;
  int n_err = 0;
  bit started = 1'b0;

  always #5 Clock = ~Clock;

  wr_bus_arbiter #(.DATA_W(16), .NREG(20), .MAX_BURST(8)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Req       (Req),
    .Lock      (Lock),
    .Req_dest  (Req_dest),
    .Req_data  (Req_data),
    .Grant     (Grant),
    .WRDec_out (WRDec_out),
    .Bus_out   (Bus_out),
    .Err       (Err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] d, input logic [15:0] v);
    Req_dest[5*i +: 5]  = d;
    Req_data[16*i +: 16] = v;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [19:0] w,
                         input logic [15:0] b, input logic e);
    chk({tag, "_grant"}, 32'(Grant), 32'(g));
    chk({tag, "_wrdec"}, 32'(WRDec_out), 32'(w));
    chk({tag, "_bus"}, 32'(Bus_out), 32'(b));
    chk({tag, "_err"}, 32'(Err), 32'(e));
  endtask

  task automatic do_reset();
    Req     = '0;
    Lock    = '0;
    Reset_n = 1'b0;
    #1;
    chk_out("rst", 4'h0, 20'h0, 16'h0, 1'b0);
    step();
    Reset_n = 1'b1;
  endtask

  always @(negedge Clock) begin
    if (started && Reset_n === 1'b1) begin
      chk("oh_grant", 32'($onehot0(Grant)), 32'd1);
      chk("oh_wrdec", 32'($onehot0(WRDec_out)), 32'd1);
      chk("wrdec_needs_grant", 32'((WRDec_out == 0) || (Grant != 0)), 32'd1);
    end
  end

  initial begin
    #2;
    do_reset();
    started = 1'b1;

    // Single request: dest 5, data 00A5
    Req = 4'b0001;
    set_req(0, 5'd5, 16'h00A5);
    step();
    chk_out("single", 4'b0001, 20'h00020, 16'h00A5, 1'b0);
    Req = 4'b0000;
    step();
    chk_out("single_after", 4'b0000, 20'h0, 16'h00A5, 1'b0);

    // All four held, no lock: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 16'h1000 + 16'(i));
    Req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      step();
      chk_out("rr", 4'(1 << (s % 4)), 20'(1 << ((s % 4) + 1)), 16'h1000 + 16'(s % 4), 1'b0);
    end
    Req = 4'b0000;
    step();
    chk_out("rr_idle", 4'b0000, 20'h0, 16'h1000, 1'b0);

    // Locked burst of requester 1, requester 2 waiting
    do_reset();
    set_req(1, 5'd7, 16'hBEEF);
    set_req(2, 5'd9, 16'hCAFE);
    Req  = 4'b0110;
    Lock = 4'b0010;
    for (int s = 0; s < 8; s++) begin
      step();
      chk_out("burst", 4'b0010, 20'h00080, 16'hBEEF, 1'b0);
    end
    step();
    chk_out("burst_exit", 4'b0000, 20'h0, 16'hBEEF, 1'b0);
    step();
    chk_out("burst_next", 4'b0100, 20'h00200, 16'hCAFE, 1'b0);
    Req  = 4'b0000;
    Lock = 4'b0000;
    step();
    chk_out("burst_done", 4'b0000, 20'h0, 16'hCAFE, 1'b0);

    // Out-of-range destination and the last legal index
    do_reset();
    set_req(3, 5'd20, 16'h3333);
    Req = 4'b1000;
    step();
    chk_out("dest20", 4'b1000, 20'h0, 16'h3333, 1'b1);
    Req = 4'b0000;
    step();
    chk_out("dest20_after", 4'b0000, 20'h0, 16'h3333, 1'b0);
    set_req(3, 5'd19, 16'h4444);
    Req = 4'b1000;
    step();
    chk_out("dest19", 4'b1000, 20'h80000, 16'h4444, 1'b0);
    Req = 4'b0000;
    step();

    // Reset during the 3rd grant of a locked burst
    do_reset();
    set_req(0, 5'd1, 16'h0A0A);
    Req  = 4'b0001;
    Lock = 4'b0001;
    for (int s = 0; s < 3; s++) begin
      step();
      chk_out("lock_pre", 4'b0001, 20'h00002, 16'h0A0A, 1'b0);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    chk_out("async_rst", 4'b0000, 20'h0, 16'h0, 1'b0);
    Lock = 4'b0000;
    Req  = 4'b1010;
    set_req(1, 5'd2, 16'h1111);
    set_req(3, 5'd3, 16'h3333);
    step();
    Reset_n = 1'b1;
    step();
    chk_out("post_rst_first", 4'b0010, 20'h00004, 16'h1111, 1'b0);
    step();
    chk_out("post_rst_second", 4'b1000, 20'h00008, 16'h3333, 1'b0);
    Req = 4'b0000;
    step();
    chk_out("post_rst_idle", 4'b0000, 20'h0, 16'h3333, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
